// File: rtl/ex_muldiv_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_stage_pkg
// Brief    : Shared encodings for the execute stage with the RV32M unit:
//            M-op codes, forwarding selects, MD FSM states, ALU op codes.
// Revision : 1.0 - initial release
// ============================================================================
package ex_muldiv_stage_pkg;

   // M-extension funct3 encodings
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   // Forwarding source selects
   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   // Mul/div sequencer states
   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // Single-cycle ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;

   // MEM has priority over WB; x0 is never forwarded
   function automatic logic [1:0] fwd_sel(input logic       wr_mem,
                                          input logic [4:0] rd_mem,
                                          input logic       wr_wb,
                                          input logic [4:0] rd_wb,
                                          input logic [4:0] rs);
      if (wr_mem && (rd_mem != 5'd0) && (rd_mem == rs))
         return FWD_MEM;
      else if (wr_wb && (rd_wb != 5'd0) && (rd_wb == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   // rs1 is treated as signed by everything except the fully-unsigned ops
   function automatic logic op_a_signed(input logic [2:0] op);
      return !((op == MD_MULHU) || (op == MD_DIVU) || (op == MD_REMU));
   endfunction

   // rs2 is treated as signed only by MUL/MULH/DIV/REM
   function automatic logic op_b_signed(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_stage_md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_iter_unit
// Brief    : Iterative radix-2 magnitude multiplier / restoring divider.
//            One step per cycle, XLEN steps. hi/lo hold product {hi,lo}
//            or remainder (hi) / quotient (lo) once the last step retires.
// Revision : 1.0 - initial release
// ============================================================================
module md_iter_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill_i,
   input  logic            start_i,
   input  logic            is_div_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   localparam logic [5:0] c_CNT_LAST = 6'(XLEN - 1);

   logic            busy_q;
   logic            is_div_q;
   logic [5:0]      cnt_q;
   logic [XLEN-1:0] hi_q, lo_q, b_q;
   logic [XLEN-1:0] hi_d, lo_d;
   logic [XLEN:0]   w_mul_sum, w_div_shift, w_div_diff;
   logic            w_div_ge;

   // One radix-2 step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      w_div_shift = {hi_q, lo_q[XLEN-1]};
      w_div_diff  = w_div_shift - {1'b0, b_q};
      // partial remainder < divisor, so the borrow bit alone tells the sign
      w_div_ge    = ~w_div_diff[XLEN];
      if (is_div_q) begin
         hi_d = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], w_div_ge};
      end else begin
         hi_d = w_mul_sum[XLEN:1];
         lo_d = {w_mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Load on start, iterate while busy, kill abandons the operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= 1'b0;
         is_div_q <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
      end else if (kill_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start_i) begin
         busy_q   <= 1'b1;
         is_div_q <= is_div_i;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= a_i;
         b_q      <= b_i;
      end else if (busy_q) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + 6'd1;
         if (cnt_q == c_CNT_LAST) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end
      end
   end

   // done marks the cycle in which the final step is being performed
   assign done_o = busy_q && (cnt_q == c_CNT_LAST);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_stage
// Brief    : Execute stage: MEM/WB forwarding, single-cycle ALU, and an
//            iterative RV32M mul/div unit that freezes the pipe via stall_ex.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_stage
   import ex_muldiv_stage_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int EARLY_OUT = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush_ex,
   input  logic [3:0]      ALUCode_ex,
   input  logic            MDValid_ex,
   input  logic [2:0]      MDOp_ex,
   input  logic            ALUSrcA_ex,
   input  logic [1:0]      ALUSrcB_ex,
   input  logic [XLEN-1:0] Imm_ex,
   input  logic [XLEN-1:0] PC_ex,
   input  logic [4:0]      rs1Addr_ex,
   input  logic [4:0]      rs2Addr_ex,
   input  logic [XLEN-1:0] rs1Data_ex,
   input  logic [XLEN-1:0] rs2Data_ex,
   input  logic [XLEN-1:0] ALUResult_mem,
   input  logic [XLEN-1:0] RegWriteData_wb,
   input  logic [4:0]      rdAddr_mem,
   input  logic [4:0]      rdAddr_wb,
   input  logic            RegWrite_mem,
   input  logic            RegWrite_wb,
   output logic [XLEN-1:0] ALUResult_ex,
   output logic [XLEN-1:0] MemWriteData_ex,
   output logic [XLEN-1:0] ALU_A,
   output logic [XLEN-1:0] ALU_B,
   output logic            stall_ex
);

   localparam int              c_SHW  = $clog2(XLEN);
   localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

   logic [1:0]        w_sel_a, w_sel_b;
   logic [XLEN-1:0]   w_rs1_fwd, w_rs2_fwd, w_alu_res;
   md_state_e         state_q;
   logic [XLEN-1:0]   rs1_q, rs2_q, result_q;
   logic [2:0]        op_q;
   logic              early_q;
   logic              w_start, w_a_sgn, w_b_sgn, w_neg_a, w_neg_b, w_is_div;
   logic              w_div0, w_ovf, w_early, w_iter_done;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_early_res, w_hi, w_lo;
   logic              w_l_neg_a, w_l_neg_b, w_l_div0;
   logic [2*XLEN-1:0] w_prod, w_prod_fix;
   logic [XLEN-1:0]   w_quo, w_rem, w_md_res;

   // Operand forwarding and ALU operand muxes
   always_comb begin
      w_sel_a = fwd_sel(RegWrite_mem, rdAddr_mem, RegWrite_wb, rdAddr_wb, rs1Addr_ex);
      w_sel_b = fwd_sel(RegWrite_mem, rdAddr_mem, RegWrite_wb, rdAddr_wb, rs2Addr_ex);
      case (w_sel_a)
         FWD_MEM: w_rs1_fwd = ALUResult_mem;
         FWD_WB:  w_rs1_fwd = RegWriteData_wb;
         default: w_rs1_fwd = rs1Data_ex;
      endcase
      case (w_sel_b)
         FWD_MEM: w_rs2_fwd = ALUResult_mem;
         FWD_WB:  w_rs2_fwd = RegWriteData_wb;
         default: w_rs2_fwd = rs2Data_ex;
      endcase
      ALU_A = ALUSrcA_ex ? PC_ex : w_rs1_fwd;
      case (ALUSrcB_ex)
         2'd0:    ALU_B = w_rs2_fwd;
         2'd1:    ALU_B = Imm_ex;
         2'd2:    ALU_B = c_FOUR;
         default: ALU_B = '0;
      endcase
   end

   assign MemWriteData_ex = w_rs2_fwd;

   // Single-cycle ALU
   always_comb begin
      case (ALUCode_ex)
         ALU_ADD:  w_alu_res = ALU_A + ALU_B;
         ALU_SUB:  w_alu_res = ALU_A - ALU_B;
         ALU_SLL:  w_alu_res = ALU_A << ALU_B[c_SHW-1:0];
         ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(ALU_A) < $signed(ALU_B)};
         ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, ALU_A < ALU_B};
         ALU_XOR:  w_alu_res = ALU_A ^ ALU_B;
         ALU_SRL:  w_alu_res = ALU_A >> ALU_B[c_SHW-1:0];
         ALU_SRA:  w_alu_res = $unsigned($signed(ALU_A) >>> ALU_B[c_SHW-1:0]);
         ALU_OR:   w_alu_res = ALU_A | ALU_B;
         ALU_AND:  w_alu_res = ALU_A & ALU_B;
         ALU_LUI:  w_alu_res = ALU_B;
         default:  w_alu_res = '0;
      endcase
   end

   // Start-cycle decode: magnitudes and the divide special cases
   always_comb begin
      w_start     = (state_q == MD_IDLE) && MDValid_ex && !flush_ex;
      w_a_sgn     = op_a_signed(MDOp_ex);
      w_b_sgn     = op_b_signed(MDOp_ex);
      w_neg_a     = w_a_sgn && w_rs1_fwd[XLEN-1];
      w_neg_b     = w_b_sgn && w_rs2_fwd[XLEN-1];
      w_mag_a     = w_neg_a ? -w_rs1_fwd : w_rs1_fwd;
      w_mag_b     = w_neg_b ? -w_rs2_fwd : w_rs2_fwd;
      w_is_div    = MDOp_ex[2];
      w_div0      = w_is_div && (w_rs2_fwd == '0);
      w_ovf       = w_is_div && w_a_sgn && (w_rs1_fwd == c_MIN) && (w_rs2_fwd == '1);
      w_early     = (EARLY_OUT != 0) && (w_div0 || w_ovf);
      // MDOp[1] set means remainder; overflow quotient equals the dividend (MIN)
      if (w_div0)
         w_early_res = MDOp_ex[1] ? w_rs1_fwd : '1;
      else
         w_early_res = MDOp_ex[1] ? '0 : w_rs1_fwd;
   end

   md_iter_unit #(
      .XLEN     (XLEN)
   ) u_iter (
      .clk      (clk),
      .rst      (reset),
      .kill_i   (flush_ex),
      .start_i  (w_start && !w_early),
      .is_div_i (w_is_div),
      .a_i      (w_mag_a),
      .b_i      (w_mag_b),
      .done_o   (w_iter_done),
      .hi_o     (w_hi),
      .lo_o     (w_lo)
   );

   // Mul/div sequencer: latches operands at start, waits for the core
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= MD_IDLE;
         rs1_q    <= '0;
         rs2_q    <= '0;
         op_q     <= '0;
         early_q  <= 1'b0;
         result_q <= '0;
      end else if (flush_ex) begin
         state_q <= MD_IDLE;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (w_start) begin
                  rs1_q   <= w_rs1_fwd;
                  rs2_q   <= w_rs2_fwd;
                  op_q    <= MDOp_ex;
                  early_q <= w_early;
                  if (w_early)
                     result_q <= w_early_res;
                  state_q <= w_early ? MD_DONE : MD_BUSY;
               end
            end
            MD_BUSY: if (w_iter_done) state_q <= MD_DONE;
            MD_DONE: state_q <= MD_IDLE;
            default: state_q <= MD_IDLE;
         endcase
      end
   end

   // Sign correction of the magnitude result from the latched operands
   always_comb begin
      w_l_neg_a  = op_a_signed(op_q) && rs1_q[XLEN-1];
      w_l_neg_b  = op_b_signed(op_q) && rs2_q[XLEN-1];
      w_l_div0   = (rs2_q == '0);
      w_prod     = {w_hi, w_lo};
      w_prod_fix = (w_l_neg_a ^ w_l_neg_b) ? -w_prod : w_prod;
      // a zero divisor leaves the quotient all ones regardless of signs
      w_quo      = ((w_l_neg_a ^ w_l_neg_b) && !w_l_div0) ? -w_lo : w_lo;
      w_rem      = w_l_neg_a ? -w_hi : w_hi;
      if (early_q)
         w_md_res = result_q;
      else if (op_q[2])
         w_md_res = op_q[1] ? w_rem : w_quo;
      else if (op_q == MD_MUL)
         w_md_res = w_prod_fix[XLEN-1:0];
      else
         w_md_res = w_prod_fix[2*XLEN-1:XLEN];
   end

   assign ALUResult_ex = ((state_q == MD_DONE) && !flush_ex) ? w_md_res : w_alu_res;
   assign stall_ex     = !reset && !flush_ex &&
                         (((state_q == MD_IDLE) && MDValid_ex) || (state_q == MD_BUSY));

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_stage
// Brief    : Self-checking bench for ex_muldiv_stage: forwarding, ALU path,
//            mul/div results against a reference model, latency, early-out,
//            flush, operand capture and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_stage;
   import ex_muldiv_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush_ex, MDValid_ex, ALUSrcA_ex;
   logic [3:0]  ALUCode_ex;
   logic [2:0]  MDOp_ex;
   logic [1:0]  ALUSrcB_ex;
   logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex, ALUResult_mem, RegWriteData_wb;
   logic [4:0]  rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb;
   logic        RegWrite_mem, RegWrite_wb;
   logic [31:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B;
   logic        stall_ex;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   ex_muldiv_stage #(.XLEN(32), .EARLY_OUT(1)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush_ex        (flush_ex),
      .ALUCode_ex      (ALUCode_ex),
      .MDValid_ex      (MDValid_ex),
      .MDOp_ex         (MDOp_ex),
      .ALUSrcA_ex      (ALUSrcA_ex),
      .ALUSrcB_ex      (ALUSrcB_ex),
      .Imm_ex          (Imm_ex),
      .PC_ex           (PC_ex),
      .rs1Addr_ex      (rs1Addr_ex),
      .rs2Addr_ex      (rs2Addr_ex),
      .rs1Data_ex      (rs1Data_ex),
      .rs2Data_ex      (rs2Data_ex),
      .ALUResult_mem   (ALUResult_mem),
      .RegWriteData_wb (RegWriteData_wb),
      .rdAddr_mem      (rdAddr_mem),
      .rdAddr_wb       (rdAddr_wb),
      .RegWrite_mem    (RegWrite_mem),
      .RegWrite_wb     (RegWrite_wb),
      .ALUResult_ex    (ALUResult_ex),
      .MemWriteData_ex (MemWriteData_ex),
      .ALU_A           (ALU_A),
      .ALU_B           (ALU_B),
      .stall_ex        (stall_ex)
   );

   // Reference model using 64-bit arithmetic plus the RISC-V special cases
   function automatic logic [31:0] md_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      longint      sa, sb, ua_s;
      logic [63:0] ua, ub, p;
      sa   = $signed(a);
      sb   = $signed(b);
      ua   = {32'd0, a};
      ub   = {32'd0, b};
      ua_s = ua;
      case (op)
         MD_MUL:    begin p = sa * sb;         return p[31:0];  end
         MD_MULH:   begin p = sa * sb;         return p[63:32]; end
         MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
         MD_MULHU:  begin p = ua * ub;         return p[63:32]; end
         MD_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         MD_DIVU: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         MD_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   task automatic idle_inputs();
      flush_ex = 0; MDValid_ex = 0; MDOp_ex = MD_MUL; ALUCode_ex = ALU_ADD;
      ALUSrcA_ex = 0; ALUSrcB_ex = 2'd0; Imm_ex = 32'h100; PC_ex = 32'h1000;
      rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = 0; rs2Data_ex = 0;
      ALUResult_mem = 0; RegWriteData_wb = 0; rdAddr_mem = 0; rdAddr_wb = 0;
      RegWrite_mem = 0; RegWrite_wb = 0;
   endtask

   // Drive one M op, measure stall length, compare result from the scoreboard
   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input bit use_fwd, input string name);
      int          n;
      logic [31:0] exp_res, after_exp;
      sb_q.push_back(md_model(op, a, b));
      ALUCode_ex = ALU_ADD; ALUSrcA_ex = 0; ALUSrcB_ex = 2'd0;
      if (use_fwd) begin
         rs1Addr_ex = 5'd3; rs2Addr_ex = 5'd4;
         RegWrite_mem = 1; rdAddr_mem = 5'd3; ALUResult_mem = a;
         RegWrite_wb = 1;  rdAddr_wb = 5'd4;  RegWriteData_wb = b;
         rs1Data_ex = $urandom; rs2Data_ex = $urandom;
      end else begin
         rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2;
         RegWrite_mem = 0; RegWrite_wb = 0;
         rs1Data_ex = a; rs2Data_ex = b;
      end
      MDOp_ex = op; MDValid_ex = 1;
      #1;
      n = 0;
      while (stall_ex === 1'b1 && n < 200) begin
         n++;
         @(posedge clk); #1;
         if (use_fwd && stall_ex === 1'b1) begin
            ALUResult_mem = $urandom; RegWriteData_wb = $urandom; #1;
         end
      end
      total++;
      if (n != exp_lat) begin
         bad++; $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_lat);
      end
      exp_res = sb_q.pop_front();
      total++;
      if (ALUResult_ex !== exp_res) begin
         bad++; $display("FAIL %s_result: got %h expected %h", name, ALUResult_ex, exp_res);
      end
      after_exp = use_fwd ? (ALUResult_mem + RegWriteData_wb) : (a + b);
      MDValid_ex = 0;
      @(posedge clk); #1;
      total++;
      if (ALUResult_ex !== after_exp || stall_ex !== 1'b0) begin
         bad++; $display("FAIL %s_one_cycle: got %h/%b expected %h/0", name, ALUResult_ex, stall_ex, after_exp);
      end
      RegWrite_mem = 0; RegWrite_wb = 0;
   endtask

   task automatic test_reset();
      reset = 1; idle_inputs();
      rs1Data_ex = 32'h10; rs2Data_ex = 32'h20;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (stall_ex !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall_ex); end
      reset = 0;
      @(posedge clk); #1;
      total++;
      if (ALUResult_ex !== 32'h30) begin bad++; $display("FAIL reset_alu: got %h expected %h", ALUResult_ex, 32'h30); end
      total++;
      if (stall_ex !== 1'b0) begin bad++; $display("FAIL reset_idle_stall: got %b expected 0", stall_ex); end
   endtask

   task automatic test_forwarding();
      rs1Addr_ex = 5'd5; rs2Addr_ex = 5'd6; rs1Data_ex = 32'h33; rs2Data_ex = 32'h44;
      RegWrite_mem = 1; rdAddr_mem = 5'd5; ALUResult_mem = 32'h11;
      RegWrite_wb = 1;  rdAddr_wb = 5'd5;  RegWriteData_wb = 32'h22;
      #1;
      total++;
      if (ALU_A !== 32'h11) begin bad++; $display("FAIL fwd_mem_priority: got %h expected %h", ALU_A, 32'h11); end
      total++;
      if (ALUResult_ex !== 32'h55) begin bad++; $display("FAIL fwd_alu_add: got %h expected %h", ALUResult_ex, 32'h55); end
      RegWrite_mem = 0; #1;
      total++;
      if (ALU_A !== 32'h22) begin bad++; $display("FAIL fwd_wb: got %h expected %h", ALU_A, 32'h22); end
      rdAddr_wb = 5'd6; #1;
      total++;
      if (MemWriteData_ex !== 32'h22) begin bad++; $display("FAIL fwd_rs2_wb: got %h expected %h", MemWriteData_ex, 32'h22); end
      RegWrite_mem = 1; rdAddr_mem = 5'd0; rdAddr_wb = 5'd0; rs1Addr_ex = 5'd0; #1;
      total++;
      if (ALU_A !== 32'h33) begin bad++; $display("FAIL fwd_x0: got %h expected %h", ALU_A, 32'h33); end
      ALUSrcA_ex = 1; ALUSrcB_ex = 2'd1; #1;
      total++;
      if (ALU_A !== 32'h1000 || ALU_B !== 32'h100) begin
         bad++; $display("FAIL mux_pc_imm: got %h/%h expected %h/%h", ALU_A, ALU_B, 32'h1000, 32'h100);
      end
      ALUSrcB_ex = 2'd2; ALUCode_ex = ALU_SUB; #1;
      total++;
      if (ALUResult_ex !== 32'hFFC) begin bad++; $display("FAIL mux_const4_sub: got %h expected %h", ALUResult_ex, 32'hFFC); end
      idle_inputs(); #1;
   endtask

   task automatic test_arith();
      run_md(MD_MUL,    32'd7,         32'hFFFF_FFFD, 33, 0, "mul_7_m3");
      run_md(MD_DIV,    32'hFFFF_FFF9, 32'd2,         33, 0, "div_m7_2");
      run_md(MD_REM,    32'hFFFF_FFF9, 32'd2,         33, 0, "rem_m7_2");
      run_md(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, "mulhu_max");
      run_md(MD_MULH,   32'h8000_0000, 32'h8000_0000, 33, 0, "mulh_min");
      run_md(MD_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, 0, "mulhsu_neg");
      run_md(MD_DIVU,   32'hFFFF_FFF0, 32'd3,         33, 0, "divu_big");
      run_md(MD_REM,    32'd7,         32'hFFFF_FFFE, 33, 0, "rem_7_m2");
      for (int i = 0; i < 4; i++)
         run_md(3'($urandom_range(0, 7)), $urandom, $urandom | 32'h1, 33, 0, "random");
   endtask

   task automatic test_early_out();
      run_md(MD_DIVU, 32'd9,         32'd0,         1, 0, "divu_by0");
      run_md(MD_REM,  32'hFFFF_FFF9, 32'd0,         1, 0, "rem_by0");
      run_md(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 0, "div_ovf");
      run_md(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 0, "rem_ovf");
   endtask

   task automatic test_flush();
      rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = 32'd5; rs2Data_ex = 32'd6;
      MDOp_ex = MD_MUL; MDValid_ex = 1; #1;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (stall_ex !== 1'b1) begin bad++; $display("FAIL flush_pre_stall: got %b expected 1", stall_ex); end
      flush_ex = 1; #1;
      total++;
      if (stall_ex !== 1'b0) begin bad++; $display("FAIL flush_stall_drop: got %b expected 0", stall_ex); end
      total++;
      if (ALUResult_ex !== 32'd11) begin bad++; $display("FAIL flush_no_result: got %h expected %h", ALUResult_ex, 32'd11); end
      @(posedge clk); #1;
      flush_ex = 0; MDValid_ex = 0; #1;
      total++;
      if (stall_ex !== 1'b0) begin bad++; $display("FAIL flush_after: got %b expected 0", stall_ex); end
      run_md(MD_MUL, 32'd3, 32'd4, 33, 0, "mul_after_flush");
   endtask

   task automatic test_capture();
      run_md(MD_DIV, 32'd100, 32'd7, 33, 1, "capture_div");
      run_md(MD_MULHSU, 32'h8765_4321, 32'hF000_000F, 33, 1, "capture_mulhsu");
   endtask

   task automatic test_reset_mid_busy();
      rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = 32'd100; rs2Data_ex = 32'd7;
      MDOp_ex = MD_DIV; MDValid_ex = 1; #1;
      repeat (6) @(posedge clk);
      #1;
      reset = 1; #1;
      total++;
      if (stall_ex !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b expected 0", stall_ex); end
      @(posedge clk); #1;
      reset = 0; MDValid_ex = 0; #1;
      total++;
      if (stall_ex !== 1'b0) begin bad++; $display("FAIL reset_release: got %b expected 0", stall_ex); end
      run_md(MD_REMU, 32'd100, 32'd7, 33, 0, "remu_after_reset");
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_arith();
      test_early_out();
      test_flush();
      test_capture();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
